// File: rtl/seg_hex_reader.sv
// Recovers per-digit hex nibbles from a multiplexed active-low 7-segment bus.
// Each sample is synchronised and stability-filtered, and changes are reported on a valid/ready port.
module seg_hex_reader #(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned STABLE_CYCLES = 4,
  localparam int unsigned IdxW         = $clog2(DIGITS),
  localparam int unsigned CntW         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [6:0]            seg_i,
  input  logic [DIGITS-1:0]     an_i,
  output logic [4*DIGITS-1:0]   digit_o,
  output logic [DIGITS-1:0]     err_o,
  output logic                  upd_valid_o,
  output logic [IdxW-1:0]       upd_idx_o,
  output logic [4:0]            upd_data_o,
  input  logic                  upd_ready_i,
  output logic                  ovf_o,
  input  logic                  ovf_clr_i
);

  logic [6:0]          seg_s1_q, seg_s2_q;
  logic [DIGITS-1:0]   an_s1_q, an_s2_q;
  logic [IdxW-1:0]     cand_idx_q, cand_idx_d, cand_idx;
  logic [6:0]          cand_seg_q, cand_seg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [4*DIGITS-1:0] digit_q, digit_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                upd_valid_q, upd_valid_d;
  logic [IdxW-1:0]     upd_idx_q, upd_idx_d;
  logic [4:0]          upd_data_q, upd_data_d;
  logic                ovf_q, ovf_d;
  logic [DIGITS-1:0]   sel;
  logic                cand_valid, same, capture, ev, drop, xfer;
  logic [4:0]          dec, ev_data;
  logic [3:0]          cur_nib;

  // Returns {hit, nibble}; hit=0 for any pattern that is not a hex glyph.
  function automatic logic [4:0] decode(input logic [6:0] p);
    unique case (p)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1a;
      7'b0000011: decode = 5'h1b;
      7'b1000110: decode = 5'h1c;
      7'b0100001: decode = 5'h1d;
      7'b0000110: decode = 5'h1e;
      7'b0001110: decode = 5'h1f;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg_i;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an_i;
      an_s2_q  <= an_s1_q;
    end
  end

  always_comb begin
    sel        = ~an_s2_q;
    cand_valid = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    cand_idx   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sel[i]) cand_idx = IdxW'(i);
    end
    same       = (cand_idx == cand_idx_q) && (seg_s2_q == cand_seg_q);
    cand_idx_d = cand_idx_q;
    cand_seg_d = cand_seg_q;
    cnt_d      = '0;
    if (cand_valid) begin
      cand_idx_d = cand_idx;
      cand_seg_d = seg_s2_q;
      if (!same)                                 cnt_d = CntW'(1);
      else if (cnt_q == CntW'(STABLE_CYCLES))    cnt_d = cnt_q;
      else                                       cnt_d = cnt_q + CntW'(1);
    end
    // A new run restarting at the threshold (STABLE_CYCLES=1) must still capture.
    capture = cand_valid && (cnt_d == CntW'(STABLE_CYCLES))
              && ((cnt_q != CntW'(STABLE_CYCLES)) || !same);
  end

  always_comb begin
    digit_d = digit_q;
    err_d   = err_q;
    dec     = decode(seg_s2_q);
    cur_nib = digit_q[4*cand_idx +: 4];
    ev_data = dec[4] ? {1'b0, dec[3:0]} : {1'b1, cur_nib};
    ev      = 1'b0;
    if (capture) begin
      ev              = (ev_data != {err_q[cand_idx], cur_nib});
      err_d[cand_idx] = ev_data[4];
      digit_d[4*cand_idx +: 4] = ev_data[3:0];
    end
  end

  always_comb begin
    upd_valid_d = upd_valid_q;
    upd_idx_d   = upd_idx_q;
    upd_data_d  = upd_data_q;
    xfer        = upd_valid_q && upd_ready_i;
    drop        = 1'b0;
    if (ev) begin
      if (!upd_valid_q || xfer) begin
        upd_valid_d = 1'b1;
        upd_idx_d   = cand_idx;
        upd_data_d  = ev_data;
      end else begin
        drop = 1'b1;
      end
    end else if (xfer) begin
      upd_valid_d = 1'b0;
    end
    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cand_idx_q  <= '0;
      cand_seg_q  <= '1;
      cnt_q       <= '0;
      digit_q     <= '0;
      err_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cand_idx_q  <= cand_idx_d;
      cand_seg_q  <= cand_seg_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      err_q       <= err_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
      upd_data_q  <= upd_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign digit_o     = digit_q;
  assign err_o       = err_q;
  assign upd_valid_o = upd_valid_q;
  assign upd_idx_o   = upd_idx_q;
  assign upd_data_o  = upd_data_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_seg_hex_reader.sv
// Directed and randomised bench for seg_hex_reader, checked against a sample-history
// reference model of the capture, decode and event rules.
module tb_seg_hex_reader;

  localparam int Stable = 4;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [6:0]  seg_i;
  logic [7:0]  an_i;
  logic [31:0] digit_o;
  logic [7:0]  err_o;
  logic        upd_valid_o;
  logic [2:0]  upd_idx_o;
  logic [4:0]  upd_data_o;
  logic        upd_ready_i;
  logic        ovf_o;
  logic        ovf_clr_i;

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;

  // Reference model state
  logic [6:0]  m_seg1, m_seg2, m_prev_seg;
  logic [7:0]  m_an1, m_an2, m_prev_an;
  logic        m_prev_ok;
  int          m_run;
  logic [31:0] m_digit;
  logic [7:0]  m_errv;
  logic        m_pv, m_ovf;
  logic [2:0]  m_pidx;
  logic [4:0]  m_pdata;

  always #5 clk_i = ~clk_i;

  seg_hex_reader #(.DIGITS(8), .STABLE_CYCLES(Stable)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .seg_i       (seg_i),
    .an_i        (an_i),
    .digit_o     (digit_o),
    .err_o       (err_o),
    .upd_valid_o (upd_valid_o),
    .upd_idx_o   (upd_idx_o),
    .upd_data_o  (upd_data_o),
    .upd_ready_i (upd_ready_i),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seg1 = '1; m_seg2 = '1; m_an1 = '1; m_an2 = '1;
    m_prev_seg = '1; m_prev_an = '1; m_prev_ok = 1'b0; m_run = 0;
    m_digit = '0; m_errv = '0; m_pv = 1'b0; m_pidx = '0; m_pdata = '0; m_ovf = 1'b0;
  endtask

  // Applies one clock edge to the model using the inputs present before that edge.
  task automatic model_edge();
    logic [7:0] s_an;
    logic [6:0] s_seg;
    logic       ok, ev, hit, xfer, drop;
    int         k;
    logic [3:0] nib;
    logic [4:0] newv;
    s_an = m_an2; s_seg = m_seg2;
    m_an2 = m_an1; m_seg2 = m_seg1; m_an1 = an_i; m_seg1 = seg_i;
    ok = ($countones(~s_an) == 1);
    if (!ok) m_run = 0;
    else if (m_prev_ok && s_an == m_prev_an && s_seg == m_prev_seg) m_run++;
    else m_run = 1;
    m_prev_ok = ok; m_prev_an = s_an; m_prev_seg = s_seg;
    ev = 1'b0; newv = '0; k = 0;
    if (ok && m_run == Stable) begin
      for (int i = 0; i < 8; i++) if (!s_an[i]) k = i;
      hit = 1'b0; nib = '0;
      for (int g = 0; g < 16; g++) if (GLYPH[g] == s_seg) begin hit = 1'b1; nib = 4'(g); end
      newv = hit ? {1'b0, nib} : {1'b1, m_digit[4*k +: 4]};
      ev = (newv != {m_errv[k], m_digit[4*k +: 4]});
      m_errv[k] = newv[4];
      m_digit[4*k +: 4] = newv[3:0];
    end
    xfer = m_pv && upd_ready_i;
    drop = 1'b0;
    if (ev) begin
      if (!m_pv || xfer) begin m_pv = 1'b1; m_pidx = 3'(k); m_pdata = newv; end
      else drop = 1'b1;
    end else if (xfer) m_pv = 1'b0;
    if (ovf_clr_i) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
  endtask

  task automatic step();
    logic xfer_seen;
    xfer_seen = upd_valid_o && upd_ready_i;
    @(posedge clk_i);
    model_edge();
    if (xfer_seen) n_xfer++;
    #1;
    chk("digit", 64'(digit_o), 64'(m_digit));
    chk("err", 64'(err_o), 64'(m_errv));
    chk("valid", 64'(upd_valid_o), 64'(m_pv));
    if (m_pv) begin
      chk("idx", 64'(upd_idx_o), 64'(m_pidx));
      chk("data", 64'(upd_data_o), 64'(m_pdata));
    end
    chk("ovf", 64'(ovf_o), 64'(m_ovf));
  endtask

  task automatic hold(input logic [7:0] an, input logic [6:0] seg, input int n);
    an_i = an; seg_i = seg;
    repeat (n) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_digit"}, 64'(digit_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
    chk({tag, "_valid"}, 64'(upd_valid_o), 64'd0);
    chk({tag, "_idx"}, 64'(upd_idx_o), 64'd0);
    chk({tag, "_data"}, 64'(upd_data_o), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf_o), 64'd0);
  endtask

  initial begin
    rstn_i = 1'b0; an_i = '1; seg_i = '1; upd_ready_i = 1'b0; ovf_clr_i = 1'b0;
    model_reset();
    #12;
    chk_zero("reset");
    rstn_i = 1'b1;

    // Test 1: digit 2 shows 3, capture lands on the sixth edge
    an_i = 8'b11111011; seg_i = 7'b0110000;
    repeat (5) step();
    chk("t1_early_digit", 64'(digit_o[11:8]), 64'd0);
    chk("t1_early_valid", 64'(upd_valid_o), 64'd0);
    step();
    chk("t1_digit", 64'(digit_o[11:8]), 64'd3);
    chk("t1_err", 64'(err_o[2]), 64'd0);
    chk("t1_valid", 64'(upd_valid_o), 64'd1);
    chk("t1_idx", 64'(upd_idx_o), 64'd2);
    chk("t1_data", 64'(upd_data_o), 64'b00011);
    repeat (4) step();
    chk("t1_one_event", 64'(ovf_o), 64'd0);

    // Test 2: scan glyph k onto digit k with the consumer always ready
    upd_ready_i = 1'b1;
    n_xfer = 0;
    for (int k = 0; k < 8; k++) hold(~(8'b1 << k), GLYPH[k], 8);
    chk("t2_digits", 64'(digit_o), 64'h7654_3210);
    chk("t2_xfers", 64'(n_xfer), 64'd8);
    chk("t2_ovf", 64'(ovf_o), 64'd0);

    // Test 3: blank on digit 5 flags an error and keeps the nibble
    upd_ready_i = 1'b0;
    hold(~(8'b1 << 5), 7'h7f, 8);
    chk("t3_err", 64'(err_o[5]), 64'd1);
    chk("t3_nib", 64'(digit_o[23:20]), 64'd5);
    chk("t3_data", 64'(upd_data_o), 64'b10101);
    upd_ready_i = 1'b1;
    step();
    upd_ready_i = 1'b0;

    // Test 4: two selects never capture, nor does a 3-cycle pattern
    hold(8'b11110011, GLYPH[9], 20);
    chk("t4_digits", 64'(digit_o), 64'h7654_3210);
    chk("t4_valid", 64'(upd_valid_o), 64'd0);
    hold(8'b11111110, GLYPH[9], 3);
    hold(8'hff, 7'h7f, 6);
    chk("t4_short", 64'(digit_o[3:0]), 64'd0);
    chk("t4_short_valid", 64'(upd_valid_o), 64'd0);

    // Test 5: backpressure, drop, clear, and set-beats-clear
    hold(~(8'b1 << 1), GLYPH[8], 8);
    hold(~(8'b1 << 3), GLYPH[10], 8);
    chk("t5_ovf", 64'(ovf_o), 64'd1);
    chk("t5_idx", 64'(upd_idx_o), 64'd1);
    chk("t5_data", 64'(upd_data_o), 64'b01000);
    ovf_clr_i = 1'b1;
    step();
    ovf_clr_i = 1'b0;
    chk("t5_clr", 64'(ovf_o), 64'd0);
    an_i = ~(8'b1 << 4); seg_i = GLYPH[11];
    repeat (5) step();
    ovf_clr_i = 1'b1;
    step();
    ovf_clr_i = 1'b0;
    chk("t5_set_wins", 64'(ovf_o), 64'd1);
    chk("t5_digit4", 64'(digit_o[19:16]), 64'hb);

    // Test 6: async reset with an event pending and the counter at 2
    an_i = ~(8'b1 << 6); seg_i = GLYPH[12];
    repeat (4) step();
    #2 rstn_i = 1'b0;
    #1;
    chk_zero("t6_reset");
    model_reset();
    #1 rstn_i = 1'b1;
    repeat (5) step();
    chk("t6_early", 64'(digit_o[27:24]), 64'd0);
    step();
    chk("t6_capture", 64'(digit_o[27:24]), 64'hc);

    // Randomised phase
    for (int r = 0; r < 40; r++) begin
      int sel, len;
      sel = $urandom_range(0, 9);
      if (sel < 8)       an_i = ~(8'b1 << $urandom_range(0, 7));
      else if (sel == 8) an_i = 8'hff;
      else               an_i = 8'($urandom);
      seg_i = ($urandom_range(0, 9) < 7) ? GLYPH[$urandom_range(0, 15)] : 7'($urandom);
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) begin
        upd_ready_i = 1'($urandom_range(0, 1));
        ovf_clr_i   = ($urandom_range(0, 7) == 0);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
